vector_beat_sequencer: RTL and testbench
========================================

Name: vector_beat_sequencer

Overview:
Issue controller for the vector pipeline. It accepts one vector instruction at a time from fetch/decode using a valid/ready handshake and decodes the opcode into control signals. It then sequences the instruction over NUM_BEATS element-group beats into the vector ALU / memory port, and stalls issue on a read-after-write hazard against a recent vector register write. It sits between instruction fetch and the vector register file / ALU / data memory.

Parameters:
NUM_BEATS, 4, element groups per vector instruction (>=2).
REG_W, 3, vector register index width.
WB_DEPTH, 3, cycles after a write instruction's last beat before its destination is readable.

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high
instr_valid  in  1  instruction offered
instr_ready  out  1  instruction accepted when valid&ready
opcode  in  5  vector opcode
vd  in  REG_W  R-type destination field
vs1  in  REG_W  source 1 / base register
vs2  in  REG_W  source 2 / I-type destination / store data
mem_ready  in  1  memory accepts current load/store beat
beat_valid  out  1  beat presented downstream
beat_idx  out  clog2(NUM_BEATS)  current element group
alu_op  out  4  ALU operation
reg_write, mem_read, mem_write, mem_to_reg  out  1 each  beat controls
wr_addr, rd_addr_a, rd_addr_b  out  REG_W  register addresses
done  out  1  pulse on last accepted beat
illegal  out  1  one-cycle pulse when an unimplemented opcode is accepted
busy  out  1  state != IDLE

Behaviour:
- Decode (opcode -> alu_op; dst field):
  - ADDV 00010 -> 0001, vd
  - SUBV 10001 -> 0100, vd
  - XORIV 00110 -> 0010, vs2
  - MOVV 00100 -> 0011, vd
  - LSLV 01001 -> 0101, vd
  - LSRV 01010 -> 0110, vd
  - RORV 00111 -> 0111, vd
  - ROLV 01000 -> 1000, vd
  - LOADV 01110 -> 0000, vs2, mem_read=1, mem_to_reg=1
  - STOREV 10000 -> 0000, mem_write=1, reg_write=0
  - All others: illegal.
- uses_vs2 = ADDV, SUBV, LSLV, LSRV, RORV, ROLV, STOREV. All instructions read vs1.
- States: IDLE, RUN.
- IDLE:
  - instr_ready = !hazard.
  - On accept with a legal opcode: latch fields, beat_idx=0, go to RUN.
  - On accept with an illegal opcode: illegal=1 for one cycle, stay in IDLE, no beats issued.
- RUN:
  - beat_valid=1; controls and addresses come from the latched decode and stay stable throughout the instruction.
  - Advance condition: 1 for ALU ops, mem_ready for LOADV/STOREV. While not advancing, beat_idx and all outputs are held.
  - Last beat (beat_idx==NUM_BEATS-1) with advance: done=1 and instr_ready=!hazard. This path is combinational from mem_ready. On accept, the next instruction starts at beat 0 the next cycle (back-to-back issue); otherwise the block returns to IDLE.
  - Minimum latency: accept at T, beats T+1..T+NUM_BEATS, done at T+NUM_BEATS.
- Hazard scoreboard:
  - On done of a reg_write instruction: pend_dst=wr_addr, pend_cnt=WB_DEPTH.
  - pend_cnt decrements each cycle to 0.
  - hazard=1 if the incoming vs1, or vs2 when uses_vs2, matches either:
    - pend_dst while pend_cnt!=0, or
    - the current in-flight dst during a last-beat accept when the in-flight instruction writes.
  - An illegal incoming opcode never raises hazard.
- Outputs in IDLE: beat_valid, controls and done are 0; addresses are 0.
- Reset (any time, including mid-instruction): state=IDLE, pend_cnt=0, every output 0. instr_ready is 0 while reset is high. The in-flight instruction is discarded without a done pulse.
- Control signals drive only when beat_valid=1.

Decomposition:
- Package vec_pkg: opcode localparams, ALU op codes, state encoding, decode struct {alu_op, reg_write, mem_read, mem_write, mem_to_reg, dst_is_vd, uses_vs2, legal}.
- Sub-module vec_decode: combinational opcode -> decode struct, instantiated once on the input fields. The sequencer holds the FSM, beat counter, latches and scoreboard.

Test Plan:
1. ADDV vd=1,vs1=2,vs2=3, NUM_BEATS=4 -> beats 0..3 on consecutive cycles, alu_op=0001, wr_addr=1, done on beat 3, instr_ready=0 during beats 0..2.
2. LOADV vs1=4,vs2=5 with mem_ready low on beat 1 for 2 cycles -> beat_idx holds at 1 for 3 cycles, mem_read=1, mem_to_reg=1, wr_addr=5, done after 6 beat cycles.
3. ADDV vd=2, then SUBV vs1=2 offered continuously -> SUBV accepted only after pend_cnt reaches 0 (WB_DEPTH=3 cycles after done). An independent SUBV vs1=6,vs2=7 is accepted on the last beat.
4. Opcode 11111 -> illegal pulse for 1 cycle, beat_valid stays 0, next instruction accepted the following cycle.
5. Reset asserted during beat 2 of STOREV -> outputs 0 immediately, no done, mem_write=0; the first instruction after release starts at beat 0.
6. XORIV vs1=1,vs2=6 then ADDV vs1=3,vs2=6 -> the second instruction is stalled by hazard on vs2 (dst 6); XORIV uses alu_op=0010.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared opcode/ALU encodings, FSM states and the decode record used by the
// vector issue sequencer and its opcode decoder.
package vec_pkg;

  localparam logic [4:0] OP_ADDV   = 5'b00010;
  localparam logic [4:0] OP_SUBV   = 5'b10001;
  localparam logic [4:0] OP_XORIV  = 5'b00110;
  localparam logic [4:0] OP_MOVV   = 5'b00100;
  localparam logic [4:0] OP_LSLV   = 5'b01001;
  localparam logic [4:0] OP_LSRV   = 5'b01010;
  localparam logic [4:0] OP_RORV   = 5'b00111;
  localparam logic [4:0] OP_ROLV   = 5'b01000;
  localparam logic [4:0] OP_LOADV  = 5'b01110;
  localparam logic [4:0] OP_STOREV = 5'b10000;

  localparam logic [3:0] ALU_NOP = 4'b0000;
  localparam logic [3:0] ALU_ADD = 4'b0001;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_MOV = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_LSL = 4'b0101;
  localparam logic [3:0] ALU_LSR = 4'b0110;
  localparam logic [3:0] ALU_ROR = 4'b0111;
  localparam logic [3:0] ALU_ROL = 4'b1000;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       dst_is_vd;
    logic       uses_vs2;
    logic       legal;
  } decode_t;

  // Register-to-register ALU instruction: writes back, never touches memory.
  function automatic decode_t alu_decode(input logic [3:0] op, input logic dst_is_vd,
                                         input logic uses_vs2);
    decode_t d;
    d            = '0;
    d.alu_op     = op;
    d.reg_write  = 1'b1;
    d.dst_is_vd  = dst_is_vd;
    d.uses_vs2   = uses_vs2;
    d.legal      = 1'b1;
    return d;
  endfunction

endpackage

// File: rtl/vec_decode.sv
// Combinational opcode decoder; unknown opcodes decode to all-zero (legal=0),
// which also keeps them from ever raising a hazard.
module vec_decode
  import vec_pkg::*;
(
  input  logic [4:0] opcode,
  output decode_t    dec
);

  always_comb begin
    dec = '0;
    case (opcode)
      OP_ADDV:  dec = alu_decode(ALU_ADD, 1'b1, 1'b1);
      OP_SUBV:  dec = alu_decode(ALU_SUB, 1'b1, 1'b1);
      OP_XORIV: dec = alu_decode(ALU_XOR, 1'b0, 1'b0);
      OP_MOVV:  dec = alu_decode(ALU_MOV, 1'b1, 1'b0);
      OP_LSLV:  dec = alu_decode(ALU_LSL, 1'b1, 1'b1);
      OP_LSRV:  dec = alu_decode(ALU_LSR, 1'b1, 1'b1);
      OP_RORV:  dec = alu_decode(ALU_ROR, 1'b1, 1'b1);
      OP_ROLV:  dec = alu_decode(ALU_ROL, 1'b1, 1'b1);
      OP_LOADV: begin
        dec.alu_op     = ALU_NOP;
        dec.reg_write  = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.legal      = 1'b1;
      end
      OP_STOREV: begin
        dec.alu_op    = ALU_NOP;
        dec.mem_write = 1'b1;
        dec.uses_vs2  = 1'b1;
        dec.legal     = 1'b1;
      end
      default: dec = '0;
    endcase
  end

endmodule

// File: rtl/vector_beat_sequencer.sv
// Vector issue controller: accepts one instruction, issues it over NUM_BEATS
// beats and stalls issue on read-after-write hazards against recent writes.
module vector_beat_sequencer
  import vec_pkg::*;
#(
  parameter int NUM_BEATS = 4,
  parameter int REG_W     = 3,
  parameter int WB_DEPTH  = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         instr_valid,
  output logic                         instr_ready,
  input  logic [4:0]                   opcode,
  input  logic [REG_W-1:0]             vd,
  input  logic [REG_W-1:0]             vs1,
  input  logic [REG_W-1:0]             vs2,
  input  logic                         mem_ready,
  output logic                         beat_valid,
  output logic [$clog2(NUM_BEATS)-1:0] beat_idx,
  output logic [3:0]                   alu_op,
  output logic                         reg_write,
  output logic                         mem_read,
  output logic                         mem_write,
  output logic                         mem_to_reg,
  output logic [REG_W-1:0]             wr_addr,
  output logic [REG_W-1:0]             rd_addr_a,
  output logic [REG_W-1:0]             rd_addr_b,
  output logic                         done,
  output logic                         illegal,
  output logic                         busy
);

  localparam int BW = $clog2(NUM_BEATS);
  localparam int CW = $clog2(WB_DEPTH + 1);

  state_t           state_reg;
  logic [BW-1:0]    beat_reg;
  logic [3:0]       alu_op_reg;
  logic             reg_write_reg;
  logic             mem_read_reg;
  logic             mem_write_reg;
  logic             mem_to_reg_reg;
  logic [REG_W-1:0] dst_reg;
  logic [REG_W-1:0] src_a_reg;
  logic [REG_W-1:0] src_b_reg;
  logic [REG_W-1:0] pend_dst_reg;
  logic [CW-1:0]    pend_cnt_reg;
  logic             illegal_reg;

  decode_t          dec_in;
  logic             run;
  logic             last_beat;
  logic             advance;
  logic             last_adv;
  logic             hit_a;
  logic             hit_b;
  logic             hazard;
  logic             accept;
  logic [REG_W-1:0] dst_in;

  vec_decode u_decode (
    .opcode (opcode),
    .dec    (dec_in)
  );

  assign run       = (state_reg == ST_RUN);
  assign last_beat = (beat_reg == BW'(NUM_BEATS - 1));
  assign advance   = !(mem_read_reg || mem_write_reg) || mem_ready;
  assign last_adv  = run && last_beat && advance;
  assign dst_in    = dec_in.dst_is_vd ? vd : vs2;

  // The in-flight destination only matters on the cycle its last beat retires,
  // since that is the only point in RUN where a new instruction can be taken.
  always_comb begin
    hit_a  = ((pend_cnt_reg != '0) && (vs1 == pend_dst_reg)) ||
             (last_adv && reg_write_reg && (vs1 == dst_reg));
    hit_b  = ((pend_cnt_reg != '0) && (vs2 == pend_dst_reg)) ||
             (last_adv && reg_write_reg && (vs2 == dst_reg));
    hazard = dec_in.legal && (hit_a || (dec_in.uses_vs2 && hit_b));
  end

  assign instr_ready = !reset && !hazard && (!run || last_adv);
  assign accept      = instr_valid && instr_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      beat_reg       <= '0;
      alu_op_reg     <= '0;
      reg_write_reg  <= 1'b0;
      mem_read_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;
      mem_to_reg_reg <= 1'b0;
      dst_reg        <= '0;
      src_a_reg      <= '0;
      src_b_reg      <= '0;
      pend_dst_reg   <= '0;
      pend_cnt_reg   <= '0;
      illegal_reg    <= 1'b0;
    end else begin
      illegal_reg <= 1'b0;

      if (pend_cnt_reg != '0) begin
        pend_cnt_reg <= pend_cnt_reg - 1'b1;
      end
      if (last_adv && reg_write_reg) begin
        pend_dst_reg <= dst_reg;
        pend_cnt_reg <= CW'(WB_DEPTH);
      end

      if (!run || last_adv) begin
        if (accept && dec_in.legal) begin
          state_reg      <= ST_RUN;
          beat_reg       <= '0;
          alu_op_reg     <= dec_in.alu_op;
          reg_write_reg  <= dec_in.reg_write;
          mem_read_reg   <= dec_in.mem_read;
          mem_write_reg  <= dec_in.mem_write;
          mem_to_reg_reg <= dec_in.mem_to_reg;
          dst_reg        <= dec_in.reg_write ? dst_in : '0;
          src_a_reg      <= vs1;
          src_b_reg      <= dec_in.uses_vs2 ? vs2 : '0;
        end else begin
          state_reg   <= ST_IDLE;
          beat_reg    <= '0;
          illegal_reg <= accept;
        end
      end else if (advance) begin
        beat_reg <= beat_reg + 1'b1;
      end
    end
  end

  assign beat_valid = run;
  assign beat_idx   = run ? beat_reg : '0;
  assign alu_op     = run ? alu_op_reg : '0;
  assign reg_write  = run && reg_write_reg;
  assign mem_read   = run && mem_read_reg;
  assign mem_write  = run && mem_write_reg;
  assign mem_to_reg = run && mem_to_reg_reg;
  assign wr_addr    = run ? dst_reg : '0;
  assign rd_addr_a  = run ? src_a_reg : '0;
  assign rd_addr_b  = run ? src_b_reg : '0;
  assign done       = last_adv;
  assign illegal    = illegal_reg;
  assign busy       = run;

endmodule

// File: tb/tb_vector_beat_sequencer.sv
// Directed bench for the vector issue sequencer with hand-computed
// expectations (NUM_BEATS=4, REG_W=3, WB_DEPTH=3).
module tb_vector_beat_sequencer;

  logic       clk;
  logic       reset;
  logic       instr_valid;
  logic       instr_ready;
  logic [4:0] opcode;
  logic [2:0] vd;
  logic [2:0] vs1;
  logic [2:0] vs2;
  logic       mem_ready;
  logic       beat_valid;
  logic [1:0] beat_idx;
  logic [3:0] alu_op;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic       mem_to_reg;
  logic [2:0] wr_addr;
  logic [2:0] rd_addr_a;
  logic [2:0] rd_addr_b;
  logic       done;
  logic       illegal;
  logic       busy;

  int errors = 0;
  int checks = 0;

  vector_beat_sequencer #(
    .NUM_BEATS (4),
    .REG_W     (3),
    .WB_DEPTH  (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .opcode      (opcode),
    .vd          (vd),
    .vs1         (vs1),
    .vs2         (vs2),
    .mem_ready   (mem_ready),
    .beat_valid  (beat_valid),
    .beat_idx    (beat_idx),
    .alu_op      (alu_op),
    .reg_write   (reg_write),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_to_reg  (mem_to_reg),
    .wr_addr     (wr_addr),
    .rd_addr_a   (rd_addr_a),
    .rd_addr_b   (rd_addr_b),
    .done        (done),
    .illegal     (illegal),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic offer(input logic [4:0] op, input logic [2:0] d, input logic [2:0] s1,
                       input logic [2:0] s2);
    instr_valid = 1'b1;
    opcode      = op;
    vd          = d;
    vs1         = s1;
    vs2         = s2;
  endtask

  task automatic drop();
    instr_valid = 1'b0;
    opcode      = 5'b00000;
    vd          = 3'd0;
    vs1         = 3'd0;
    vs2         = 3'd0;
  endtask

  task automatic idle(input int n);
    drop();
    repeat (n) next_cycle();
  endtask

  localparam logic [4:0] ADDV   = 5'b00010;
  localparam logic [4:0] SUBV   = 5'b10001;
  localparam logic [4:0] XORIV  = 5'b00110;
  localparam logic [4:0] LOADV  = 5'b01110;
  localparam logic [4:0] STOREV = 5'b10000;
  localparam logic [4:0] BADOP  = 5'b11111;

  initial begin
    logic mr_tab [6];
    int   ix_tab [6];
    mr_tab = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    ix_tab = '{0, 1, 1, 1, 2, 3};

    reset     = 1'b1;
    mem_ready = 1'b1;
    drop();
    repeat (2) @(posedge clk);
    #1;

    // Reset state, with a legal instruction offered
    offer(ADDV, 3'd1, 3'd2, 3'd3);
    settle();
    check("rst_ready", instr_ready, 0);
    check("rst_beat_valid", beat_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_illegal", illegal, 0);
    drop();
    reset = 1'b0;
    next_cycle();
    settle();
    check("idle_beat_valid", beat_valid, 0);
    check("idle_ready", instr_ready, 1);

    // 1: ADDV vd=1 vs1=2 vs2=3 over four consecutive beats
    offer(ADDV, 3'd1, 3'd2, 3'd3);
    settle();
    check("t1_accept_ready", instr_ready, 1);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      drop();
      settle();
      check($sformatf("t1_beat%0d_idx", i), beat_idx, i);
      check($sformatf("t1_beat%0d_valid", i), beat_valid, 1);
      check($sformatf("t1_beat%0d_done", i), done, int'(i == 3));
      check($sformatf("t1_beat%0d_ready", i), instr_ready, int'(i == 3));
      if (i == 0) begin
        check("t1_alu_op", alu_op, 1);
        check("t1_wr_addr", wr_addr, 1);
        check("t1_rd_a", rd_addr_a, 2);
        check("t1_rd_b", rd_addr_b, 3);
        check("t1_reg_write", reg_write, 1);
      end
    end
    next_cycle();
    settle();
    check("t1_after_valid", beat_valid, 0);
    check("t1_after_wr_addr", wr_addr, 0);
    check("t1_after_busy", busy, 0);

    // 2: LOADV with mem_ready low for two cycles on beat 1
    offer(LOADV, 3'd0, 3'd4, 3'd5);
    settle();
    check("t2_accept_ready", instr_ready, 1);
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      drop();
      mem_ready = mr_tab[i];
      if (i == 5) begin
        mem_ready = 1'b0;
        settle();
        check("t2_done_blocked", done, 0);
        check("t2_ready_blocked", instr_ready, 0);
        mem_ready = 1'b1;
      end
      settle();
      check($sformatf("t2_cyc%0d_idx", i), beat_idx, ix_tab[i]);
      check($sformatf("t2_cyc%0d_done", i), done, int'(i == 5));
      if (i == 2) begin
        check("t2_mem_read", mem_read, 1);
        check("t2_mem_to_reg", mem_to_reg, 1);
        check("t2_wr_addr", wr_addr, 5);
        check("t2_alu_op", alu_op, 0);
      end
    end
    mem_ready = 1'b1;
    idle(5);

    // 3: ADDV vd=2 then dependent SUBV vs1=2 waits out the scoreboard
    offer(ADDV, 3'd2, 3'd3, 3'd4);
    settle();
    check("t3_addv_ready", instr_ready, 1);
    for (int k = 1; k <= 8; k++) begin
      next_cycle();
      if (k == 1) offer(SUBV, 3'd0, 3'd2, 3'd7);
      settle();
      check($sformatf("t3_stall_cyc%0d", k), instr_ready, int'(k == 8));
    end
    next_cycle();
    offer(SUBV, 3'd3, 3'd6, 3'd7);
    settle();
    check("t3_sub_valid", beat_valid, 1);
    check("t3_sub_idx", beat_idx, 0);
    check("t3_sub_alu_op", alu_op, 4);
    check("t3_sub_rd_a", rd_addr_a, 2);
    check("t3_sub_rd_b", rd_addr_b, 7);
    for (int j = 1; j <= 3; j++) begin
      next_cycle();
      settle();
      check($sformatf("t3_indep_ready%0d", j), instr_ready, int'(j == 3));
    end
    next_cycle();
    drop();
    settle();
    check("t3_b2b_idx", beat_idx, 0);
    check("t3_b2b_valid", beat_valid, 1);
    check("t3_b2b_wr_addr", wr_addr, 3);
    check("t3_b2b_rd_a", rd_addr_a, 6);
    idle(8);

    // 4: illegal opcode pulses once and issues nothing
    offer(BADOP, 3'd0, 3'd0, 3'd0);
    settle();
    check("t4_bad_ready", instr_ready, 1);
    check("t4_bad_illegal_now", illegal, 0);
    next_cycle();
    offer(ADDV, 3'd5, 3'd0, 3'd0);
    settle();
    check("t4_illegal_pulse", illegal, 1);
    check("t4_no_beat", beat_valid, 0);
    check("t4_next_ready", instr_ready, 1);
    next_cycle();
    drop();
    settle();
    check("t4_illegal_clear", illegal, 0);
    check("t4_next_valid", beat_valid, 1);
    check("t4_next_wr_addr", wr_addr, 5);
    idle(8);

    // 5: reset in the middle of a STOREV
    offer(STOREV, 3'd0, 3'd1, 3'd2);
    settle();
    check("t5_accept_ready", instr_ready, 1);
    next_cycle();
    drop();
    settle();
    check("t5_mem_write", mem_write, 1);
    check("t5_reg_write", reg_write, 0);
    check("t5_rd_b", rd_addr_b, 2);
    next_cycle();
    next_cycle();
    settle();
    check("t5_beat2_idx", beat_idx, 2);
    reset = 1'b1;
    settle();
    check("t5_rst_valid", beat_valid, 0);
    check("t5_rst_mem_write", mem_write, 0);
    check("t5_rst_done", done, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_rd_a", rd_addr_a, 0);
    offer(ADDV, 3'd4, 3'd1, 3'd2);
    settle();
    check("t5_rst_ready", instr_ready, 0);
    next_cycle();
    settle();
    check("t5_rst_hold_done", done, 0);
    reset = 1'b0;
    settle();
    check("t5_release_ready", instr_ready, 1);
    next_cycle();
    drop();
    settle();
    check("t5_restart_idx", beat_idx, 0);
    check("t5_restart_valid", beat_valid, 1);
    check("t5_restart_wr_addr", wr_addr, 4);
    idle(8);

    // 6: XORIV writes vs2=6; following ADDV reads vs2=6 and must stall
    offer(XORIV, 3'd0, 3'd1, 3'd6);
    settle();
    check("t6_accept_ready", instr_ready, 1);
    for (int k = 1; k <= 8; k++) begin
      next_cycle();
      if (k == 1) offer(ADDV, 3'd0, 3'd3, 3'd6);
      settle();
      if (k == 1) begin
        check("t6_xor_alu_op", alu_op, 2);
        check("t6_xor_wr_addr", wr_addr, 6);
        check("t6_xor_rd_a", rd_addr_a, 1);
      end
      check($sformatf("t6_stall_cyc%0d", k), instr_ready, int'(k == 8));
    end
    next_cycle();
    drop();
    settle();
    check("t6_add_alu_op", alu_op, 1);
    check("t6_add_idx", beat_idx, 0);
    check("t6_add_rd_b", rd_addr_b, 6);
    idle(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
